// File: rtl/input_debounce_conditioner.sv
// Board input conditioner: per-bit polarity fix, 2-flop sync, counter debounce,
// registered rise/fall pulses and a sticky rising-edge capture with per-bit clear.
module input_debounce_conditioner #(
  parameter int               WIDTH           = 22,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               CNT_W           = 19,
  parameter logic [WIDTH-1:0] INVERT_MASK     = 'h00000F
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change,
  output logic [WIDTH-1:0] edge_capture,
  input  logic [WIDTH-1:0] edge_clear
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;
  logic [WIDTH-1:0] r_capture;

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  // Acceptance: the synchronised level has differed from stable for DEBOUNCE_CYCLES edges
  always_comb begin
    w_diff   = r_sync_p1 ^ r_stable;
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
    end
    w_rise = w_accept & r_sync_p1;
    w_fall = w_accept & ~r_sync_p1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_any     <= 1'b0;
      r_capture <= '0;
    end else begin
      r_sync_p0 <= raw_in ^ INVERT_MASK;
      r_sync_p1 <= r_sync_p0;
      // Any agreeing cycle or an acceptance restarts the count, so it never wraps
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_diff[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      r_stable  <= r_stable ^ w_accept;
      r_rise    <= w_rise;
      r_fall    <= w_fall;
      r_any     <= |w_accept;
      // A new rise beats a coincident clear
      r_capture <= (r_capture & ~edge_clear) | w_rise;
    end
  end

  assign stable_out   = r_stable;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign any_change   = r_any;
  assign edge_capture = r_capture;

endmodule

// File: tb/tb_input_debounce_conditioner.sv
// Scoreboard bench for input_debounce_conditioner with DEBOUNCE_CYCLES=4:
// stimulus pushes expected change events, a negedge monitor pops them on any_change.
module tb_input_debounce_conditioner;

  localparam int W = 22;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw_in;
  logic [W-1:0] stable_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         any_change;
  logic [W-1:0] edge_capture;
  logic [W-1:0] edge_clear;

  input_debounce_conditioner #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .INVERT_MASK(22'h00000F)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .raw_in(raw_in),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change),
    .edge_capture(edge_capture),
    .edge_clear(edge_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] stb;
    logic [W-1:0] cap;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_cap    = '0;

  localparam logic [W-1:0] B0 = 22'h000001;
  localparam logic [W-1:0] B4 = 22'h000010;
  localparam logic [W-1:0] B5 = 22'h000020;
  localparam logic [W-1:0] B6 = 22'h000040;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected event at edge index c; model stable/capture track pushes in order
  task automatic push_exp(input int c, input logic [W-1:0] r, input logic [W-1:0] f);
    exp_t e;
    m_stable = (m_stable | r) & ~f;
    m_cap    = m_cap | r;
    e.cyc  = c;
    e.rise = r;
    e.fall = f;
    e.stb  = m_stable;
    e.cap  = m_cap;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (any_change === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change rise %h fall %h (cycle %0d)", rise_pulse, fall_pulse, cyc);
      end else begin
        e = q.pop_front();
        chk("event_cycle", W'(cyc), W'(e.cyc));
        chk("rise_pulse", rise_pulse, e.rise);
        chk("fall_pulse", fall_pulse, e.fall);
        chk("stable_out", stable_out, e.stb);
        chk("edge_capture", edge_capture, e.cap);
      end
    end else if ((rise_pulse | fall_pulse) !== '0) begin
      checks++;
      errors++;
      $display("FAIL pulse_without_any_change rise %h fall %h (cycle %0d)", rise_pulse, fall_pulse, cyc);
    end
  end

  initial begin
    int c0;
    rst_n      = 1'b0;
    raw_in     = 22'h00000F;
    edge_clear = '0;

    // 1. reset state and quiet hold after release
    repeat (3) @(negedge clk);
    chk("rst_stable", stable_out, '0);
    chk("rst_rise", rise_pulse, '0);
    chk("rst_fall", fall_pulse, '0);
    chk("rst_any", W'(any_change), '0);
    chk("rst_capture", edge_capture, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_stable", stable_out, '0);
      chk("idle_capture", edge_capture, '0);
    end

    // 2. switch 4 on
    c0 = cyc;
    raw_in[4] = 1'b1;
    push_exp(c0 + 6, B4, '0);
    repeat (12) @(negedge clk);
    chk("sw4_level", stable_out & B4, B4);

    // 3. glitch train on bit 5 never accepted
    for (int i = 0; i < 10; i++) begin
      raw_in[5] = 1'b1;
      @(negedge clk);
      raw_in[5] = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("glitch_sw5", stable_out & B5, '0);

    // 4. KEY0 pressed for 10 cycles (active-low raw)
    c0 = cyc;
    raw_in[0] = 1'b0;
    push_exp(c0 + 6, B0, '0);
    repeat (10) @(negedge clk);
    raw_in[0] = 1'b1;
    push_exp(c0 + 16, '0, B0);
    repeat (20) @(negedge clk);
    chk("key0_capture", edge_capture & B0, B0);

    // 5. bit 4 off, then on with a clear coinciding with acceptance
    c0 = cyc;
    raw_in[4] = 1'b0;
    push_exp(c0 + 6, '0, B4);
    repeat (12) @(negedge clk);
    c0 = cyc;
    raw_in[4] = 1'b1;
    push_exp(c0 + 6, B4, '0);
    repeat (5) @(negedge clk);
    edge_clear = B4;
    @(negedge clk);
    edge_clear = '0;
    @(negedge clk);
    chk("set_beats_clear", edge_capture, B4 | B0);
    edge_clear = B4;
    @(negedge clk);
    edge_clear = '0;
    m_cap = m_cap & ~B4;
    chk("clear_capture", edge_capture, B0);
    chk("clear_keeps_stable", stable_out, B4);
    repeat (4) @(negedge clk);

    // 6. reset while bit 6 count is at 2, then restart
    c0 = cyc;
    raw_in[6] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    m_stable = '0;
    m_cap    = '0;
    @(negedge clk);
    chk("midrst_stable", stable_out, '0);
    chk("midrst_capture", edge_capture, '0);
    @(negedge clk);
    c0 = cyc;
    rst_n = 1'b1;
    push_exp(c0 + 6, B4 | B6, '0);
    repeat (5) @(negedge clk);
    chk("restart_not_early", stable_out & B6, '0);
    repeat (10) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
